// File: rtl/iopmp_check_arbiter.sv
// Round-robin sequencer that shares one IOPMP permission-check port between NUM_REQ requesters.
// One check is in flight at a time: accept (IDLE), hold CHECK_LAT cycles (CHECK), respond (RESP).
package iopmp_pkg;
  typedef enum logic [1:0] {
    ACCESS_NONE  = 2'd0,
    ACCESS_READ  = 2'd1,
    ACCESS_WRITE = 2'd2,
    ACCESS_EXEC  = 2'd3
  } iopmp_access_t;
endpackage

module iopmp_check_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PLEN      = 34,
  parameter int SID_WIDTH = 1,
  parameter int CHECK_LAT = 2,
  localparam int IDXW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NUM_REQ-1:0]                        req_valid_i,
  output logic [NUM_REQ-1:0]                        req_ready_o,
  input  logic [NUM_REQ*PLEN-1:0]                   req_addr_i,
  input  logic [NUM_REQ*SID_WIDTH-1:0]              req_sid_i,
  input  iopmp_pkg::iopmp_access_t [NUM_REQ-1:0]    req_access_i,
  output logic [NUM_REQ-1:0]                        rsp_valid_o,
  output logic                                      rsp_allow_o,
  output logic [PLEN-1:0]                           addr_o,
  output logic [SID_WIDTH-1:0]                      sid_o,
  output iopmp_pkg::iopmp_access_t                  access_type_o,
  output logic                                      check_valid_o,
  input  logic                                      tr_i,
  output logic                                      busy_o,
  output logic [IDXW-1:0]                           grant_idx_o
);

  if (CHECK_LAT < 1 || CHECK_LAT > 15) begin : g_bad_lat
    $error("iopmp_check_arbiter: CHECK_LAT must be in 1..15");
  end
  if (NUM_REQ < 1 || NUM_REQ > 16) begin : g_bad_num
    $error("iopmp_check_arbiter: NUM_REQ must be in 1..16");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [IDXW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]          grant_q, grant_d;
  logic [3:0]               lat_cnt_q, lat_cnt_d;
  logic [PLEN-1:0]          addr_q, addr_d;
  logic [SID_WIDTH-1:0]     sid_q, sid_d;
  iopmp_pkg::iopmp_access_t access_q, access_d;
  logic                     allow_q, allow_d;

  logic                     win_found;
  logic [IDXW-1:0]          win_idx;
  logic [IDXW:0]            cand;

  // Scan requesters starting at rr_ptr; cand never exceeds 2*(NUM_REQ-1) so one subtraction wraps it.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDXW+1)'(i);
      if (cand >= (IDXW+1)'(NUM_REQ)) begin
        cand = cand - (IDXW+1)'(NUM_REQ);
      end
      if (!win_found && req_valid_i[cand[IDXW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDXW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      lat_cnt_q <= '0;
      addr_q    <= '0;
      sid_q     <= '0;
      access_q  <= iopmp_pkg::ACCESS_NONE;
      allow_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      lat_cnt_q <= lat_cnt_d;
      addr_q    <= addr_d;
      sid_q     <= sid_d;
      access_q  <= access_d;
      allow_q   <= allow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    lat_cnt_d   = lat_cnt_q;
    addr_d      = addr_q;
    sid_d       = sid_q;
    access_d    = access_q;
    allow_d     = allow_q;
    req_ready_o = '0;
    rsp_valid_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          req_ready_o = NUM_REQ'(1) << win_idx;
          addr_d      = req_addr_i[int'(win_idx)*PLEN +: PLEN];
          sid_d       = req_sid_i[int'(win_idx)*SID_WIDTH +: SID_WIDTH];
          access_d    = req_access_i[win_idx];
          grant_d     = win_idx;
          lat_cnt_d   = 4'(CHECK_LAT - 1);
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (lat_cnt_q == 4'd0) begin
          allow_d = tr_i;
          state_d = ST_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        rsp_valid_o = NUM_REQ'(1) << grant_q;
        rr_ptr_d    = (grant_q == IDXW'(NUM_REQ - 1)) ? '0 : grant_q + IDXW'(1);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_allow_o   = allow_q;
  assign addr_o        = addr_q;
  assign sid_o         = sid_q;
  assign access_type_o = access_q;
  assign check_valid_o = (state_q == ST_CHECK);
  assign busy_o        = (state_q != ST_IDLE);
  assign grant_idx_o   = grant_q;

endmodule
